snow64_sub_alu_sequencer: RTL

//  Initiator side of the PortIn_SubAlu/PortOut_SubAlu interface: accepts one 64-bit PortIn_Alu request,

---
 rtl/snow64_sub_alu_sequencer_pkg.sv | 108 ++++++++++
 rtl/snow64_sub_alu_sequencer.sv | 126 ++++++++++++
 2 files changed

// File: rtl/snow64_sub_alu_sequencer_pkg.sv
// Shared types and helpers for the serial sub-ALU sequencer.
// Provides the ALU request/response port structs, the operation and element
// size encodings, the sequencer state type, and small helpers that classify a
// slice index relative to the element size (first / last / base byte).
package snow64_sub_alu_sequencer_pkg;

  localparam int WIDTH__SUB_ALU_SLICE = 8;
  localparam int WIDTH__ALU_DATA      = 64;
  localparam int WIDTH__SLICE_INDEX   = 3;

  typedef enum logic [3:0] {
    OpAdd      = 4'd0,
    OpSub      = 4'd1,
    OpSlt      = 4'd2,
    OpDummy0   = 4'd3,
    OpAnd      = 4'd4,
    OpOrr      = 4'd5,
    OpXor      = 4'd6,
    OpInv      = 4'd7,
    OpShl      = 4'd8,
    OpShr      = 4'd9,
    OpAddAgain = 4'd10,
    OpDummy1   = 4'd11,
    OpDummy2   = 4'd12,
    OpDummy3   = 4'd13,
    OpDummy4   = 4'd14,
    OpDummy5   = 4'd15
  } AluOper;

  typedef enum logic [1:0] {
    TypSz8  = 2'd0,
    TypSz16 = 2'd1,
    TypSz32 = 2'd2,
    TypSz64 = 2'd3
  } TypeSize;

  typedef enum logic [1:0] {
    SeqIdle = 2'd0,
    SeqRun  = 2'd1,
    SeqDone = 2'd2
  } SeqState;

  // 135 bits
  typedef struct packed {
    logic [WIDTH__ALU_DATA-1:0] a;
    logic [WIDTH__ALU_DATA-1:0] b;
    AluOper                     oper;
    TypeSize                    type_size;
    logic                       signedness;
  } PortIn_Alu;

  typedef struct packed {
    logic [WIDTH__ALU_DATA-1:0] data;
  } PortOut_Alu;

  // 27 bits
  typedef struct packed {
    logic [WIDTH__SUB_ALU_SLICE-1:0] a;
    logic [WIDTH__SUB_ALU_SLICE-1:0] b;
    logic                            carry;
    AluOper                          oper;
    TypeSize                         type_size;
    logic                            signedness;
    logic [WIDTH__SLICE_INDEX-1:0]   index;
  } PortIn_SubAlu;

  // 10 bits
  typedef struct packed {
    logic [WIDTH__SUB_ALU_SLICE-1:0] data;
    logic                            slts;
    logic                            carry;
  } PortOut_SubAlu;

  // Shifts and the dummy encodings have no slice-serial implementation.
  function automatic logic is_supported(input AluOper oper);
    case (oper)
      OpAdd, OpSub, OpSlt, OpAnd, OpOrr, OpXor, OpInv, OpAddAgain: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Low index bits that select a byte within one element.
  function automatic logic [WIDTH__SLICE_INDEX-1:0] elem_mask(input TypeSize type_size);
    case (type_size)
      TypSz8:  return 3'b000;
      TypSz16: return 3'b001;
      TypSz32: return 3'b011;
      default: return 3'b111;
    endcase
  endfunction

  function automatic logic elem_first(input logic [WIDTH__SLICE_INDEX-1:0] index,
                                      input TypeSize type_size);
    return (index & elem_mask(type_size)) == 3'b000;
  endfunction

  function automatic logic elem_last(input logic [WIDTH__SLICE_INDEX-1:0] index,
                                     input TypeSize type_size);
    return (index & elem_mask(type_size)) == elem_mask(type_size);
  endfunction

  // Index of the least-significant byte of the element containing index.
  function automatic logic [WIDTH__SLICE_INDEX-1:0] elem_base(
      input logic [WIDTH__SLICE_INDEX-1:0] index, input TypeSize type_size);
    return index & ~elem_mask(type_size);
  endfunction

endpackage

// File: rtl/snow64_sub_alu_sequencer.sv
// Serial initiator for a single external 8-bit sub-ALU.
// Accepts one 64-bit ALU request, walks slices 0..7 through the sub-ALU one
// per cycle, chains carry between slices of the same element and assembles
// the 64-bit result. Unsupported operations complete immediately with out_err.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   in_req_valid/in_req_ready/in_req   request handshake and PortIn_Alu payload
//   to_sub_alu      PortIn_SubAlu slice request (all zero outside RUN)
//   from_sub_alu    PortOut_SubAlu combinational slice response
//   out_valid/out_ready   result handshake
//   out_data, out_err     assembled result and unsupported-op flag
module snow64_sub_alu_sequencer
  import snow64_sub_alu_sequencer_pkg::*;
#(
  parameter int NUM_SLICES = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_req_valid,
  output logic          in_req_ready,
  input  PortIn_Alu     in_req,
  output PortIn_SubAlu  to_sub_alu,
  input  PortOut_SubAlu from_sub_alu,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [63:0]   out_data,
  output logic          out_err
);

  if (NUM_SLICES != WIDTH__ALU_DATA / WIDTH__SUB_ALU_SLICE) begin : g_bad_num_slices
    $error("NUM_SLICES must equal 64/8");
  end

  localparam logic [WIDTH__SLICE_INDEX-1:0] LAST_IDX = WIDTH__SLICE_INDEX'(NUM_SLICES - 1);

  SeqState                       state, state_nxt;
  logic [WIDTH__SLICE_INDEX-1:0] idx;
  PortIn_Alu                     req_q;
  logic                          carry_q;
  PortOut_Alu                    result_q, result_nxt;
  logic                          err_q;
  logic                          accept;
  logic                          slice_first, slice_last;
  logic                          carry_in;

  assign slice_first = elem_first(idx, req_q.type_size);
  assign slice_last  = elem_last(idx, req_q.type_size);
  // Subtract-type ops need a borrow-free +1 at the bottom of every element.
  assign carry_in    = slice_first ? ((req_q.oper == OpSub) || (req_q.oper == OpSlt)) : carry_q;

  assign out_data = result_q.data;
  assign out_err  = err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= SeqIdle;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    in_req_ready = 1'b0;
    out_valid    = 1'b0;
    accept       = 1'b0;
    to_sub_alu   = '0;
    case (state)
      SeqIdle: begin
        in_req_ready = 1'b1;
        if (in_req_valid) begin
          accept    = 1'b1;
          state_nxt = is_supported(in_req.oper) ? SeqRun : SeqDone;
        end
      end
      SeqRun: begin
        to_sub_alu.a          = req_q.a[{idx, 3'b000} +: WIDTH__SUB_ALU_SLICE];
        to_sub_alu.b          = req_q.b[{idx, 3'b000} +: WIDTH__SUB_ALU_SLICE];
        to_sub_alu.carry      = carry_in;
        to_sub_alu.oper       = req_q.oper;
        to_sub_alu.type_size  = req_q.type_size;
        to_sub_alu.signedness = req_q.signedness;
        to_sub_alu.index      = idx;
        if (idx == LAST_IDX) state_nxt = SeqDone;
      end
      SeqDone: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = SeqIdle;
      end
      default: state_nxt = SeqIdle;
    endcase
  end

  // Set-less-than only knows its answer on the top byte of an element; bytes
  // are cleared as they pass and the element's bottom byte gets slts last.
  always_comb begin
    result_nxt = result_q;
    if (req_q.oper == OpSlt) begin
      result_nxt.data[{idx, 3'b000} +: WIDTH__SUB_ALU_SLICE] = '0;
      if (slice_last)
        result_nxt.data[{elem_base(idx, req_q.type_size), 3'b000} +: WIDTH__SUB_ALU_SLICE] =
          {7'b0, from_sub_alu.slts};
    end else begin
      result_nxt.data[{idx, 3'b000} +: WIDTH__SUB_ALU_SLICE] = from_sub_alu.data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx      <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else if (accept) begin
      idx      <= '0;
      result_q <= '0;
      err_q    <= !is_supported(in_req.oper);
    end else if (state == SeqRun) begin
      idx      <= idx + 3'd1;
      result_q <= result_nxt;
    end
  end

  // Request and carry chain carry no reset; they are only read in RUN.
  always_ff @(posedge clk) begin
    if (accept)           req_q   <= in_req;
    if (state == SeqRun)  carry_q <= from_sub_alu.carry;
  end

endmodule
